// File: rtl/stsystem_tx_ctrl_if.sv
// rtl/stsystem_tx_ctrl_if.sv - parallel source and serial link signals of the transmit controller
interface stsystem_tx_ctrl_if #(
   parameter int DATA_W = 8
);
   logic              send;
   logic [DATA_W-1:0] din;
   logic              txe;
   logic              ack;
   logic              ld;
   logic              rts;
   logic              sdo;
   logic              clkout;
   logic              busy;
   logic              done;
   logic              err;

   modport master (
      output send, din, txe, ack,
      input  ld, rts, sdo, clkout, busy, done, err
   );

   modport slave (
      input  send, din, txe, ack,
      output ld, rts, sdo, clkout, busy, done, err
   );
endinterface

// File: rtl/stsystem_tx_ctrl.sv
// rtl/stsystem_tx_ctrl.sv - serial transmit controller FSM with shift/bit/timeout datapath
// Define STS_PARITY_EN to append one even-parity bit after the data word.
module stsystem_tx_ctrl #(
   parameter int DATA_W    = 8,
   parameter int MSB_FIRST = 0,
   parameter int TIMEOUT   = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   stsystem_tx_ctrl_if.slave    bus
);

`ifdef STS_PARITY_EN
   localparam int NBITS = DATA_W + 1;
`else
   localparam int NBITS = DATA_W;
`endif

   localparam int BIT_W    = $clog2(NBITS + 1);
   localparam int TMO_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam int TMO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

   localparam logic [BIT_W-1:0] BIT_MAX  = BIT_W'(NBITS);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(NBITS - 1);
   localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT);
   localparam logic [TMO_W-1:0] TMO_END  = TMO_W'(TMO_LAST);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_REQ,
      S_SHIFT,
      S_WAIT_ACK,
      S_DONE,
      S_ERR
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [NBITS-1:0]   shreg;
   logic [NBITS-1:0]   load_word;
   logic [NBITS-1:0]   shreg_shifted;
   logic [BIT_W-1:0]   bit_cnt;
   logic [TMO_W-1:0]   tmo_cnt;
   logic               phase;
   logic               cur_bit;
   logic               last_bit;
   logic               tmo_hit;

   logic               ld_c;
   logic               rts_c;
   logic               sdo_c;
   logic               clkout_c;
   logic               busy_c;
   logic               done_c;
   logic               err_c;

   // The parity bit sits at the end of the word that is shifted out last.
`ifdef STS_PARITY_EN
   assign load_word = (MSB_FIRST != 0) ? {bus.din, ^bus.din} : {^bus.din, bus.din};
`else
   assign load_word = bus.din;
`endif

   assign shreg_shifted = (MSB_FIRST != 0) ? (shreg << 1) : (shreg >> 1);
   assign cur_bit       = (MSB_FIRST != 0) ? shreg[NBITS-1] : shreg[0];
   assign last_bit      = (bit_cnt == BIT_LAST);
   // Fires on the cycle whose increment would reach TIMEOUT, so REQ/WAIT_ACK last exactly TIMEOUT cycles.
   assign tmo_hit       = (TIMEOUT > 0) && (tmo_cnt == TMO_END);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      ld_c      = 1'b0;
      rts_c     = 1'b0;
      sdo_c     = 1'b0;
      clkout_c  = 1'b0;
      done_c    = 1'b0;
      err_c     = 1'b0;
      busy_c    = (state != S_IDLE);
      case (state)
         S_IDLE: begin
            if (bus.send) begin
               state_nxt = S_LOAD;
            end
         end
         S_LOAD: begin
            ld_c      = 1'b1;
            state_nxt = S_REQ;
         end
         S_REQ: begin
            rts_c = 1'b1;
            if (bus.txe) begin
               state_nxt = S_SHIFT;
            end else if (tmo_hit) begin
               state_nxt = S_ERR;
            end
         end
         S_SHIFT: begin
            sdo_c    = cur_bit;
            clkout_c = phase;
            if (phase && last_bit) begin
               state_nxt = S_WAIT_ACK;
            end
         end
         S_WAIT_ACK: begin
            if (bus.ack) begin
               state_nxt = S_DONE;
            end else if (tmo_hit) begin
               state_nxt = S_ERR;
            end
         end
         S_DONE: begin
            done_c    = 1'b1;
            state_nxt = S_IDLE;
         end
         S_ERR: begin
            err_c     = 1'b1;
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         shreg   <= '0;
         bit_cnt <= '0;
         tmo_cnt <= '0;
         phase   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.send) begin
                  shreg <= load_word;
               end
            end
            S_LOAD: begin
               tmo_cnt <= '0;
            end
            S_REQ: begin
               if (bus.txe) begin
                  bit_cnt <= '0;
                  phase   <= 1'b0;
                  tmo_cnt <= '0;
               end else if (tmo_cnt != TMO_MAX) begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            S_SHIFT: begin
               // Holding the timeout counter at zero here gives WAIT_ACK a clean start.
               phase   <= ~phase;
               tmo_cnt <= '0;
               if (phase) begin
                  shreg <= shreg_shifted;
                  if (bit_cnt != BIT_MAX) begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
            end
            S_WAIT_ACK: begin
               if (!bus.ack && (tmo_cnt != TMO_MAX)) begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.ld     = ld_c;
   assign bus.rts    = rts_c;
   assign bus.sdo    = sdo_c;
   assign bus.clkout = clkout_c;
   assign bus.busy   = busy_c;
   assign bus.done   = done_c;
   assign bus.err    = err_c;

endmodule

// File: doc/stsystem_tx_ctrl.md
Name: stsystem_tx_ctrl

Overview:
Parametrised serial transmit controller, the next generation of the Serial Transmission System FSM. It integrates the control FSM with its datapath: a parallel-load shift register, a bit counter and request/acknowledge timeouts. It sits between the parallel data source (send/din) and the serial link (rts/txe/ack/sdo/clkout). Adds configurable word width, LSB/MSB order, timeout error reporting and optional parity.

Parameters:
DATA_W, 8, width of the parallel word (1..32)
MSB_FIRST, 0, 0 = shift LSB first, 1 = MSB first
TIMEOUT, 16, max cycles waiting in REQ or WAIT_ACK before error; 0 = wait forever

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
send  in  1  start request, sampled only in IDLE
din  in  DATA_W  parallel word, captured on the IDLE->LOAD edge
txe  in  1  receiver ready (transmit enable)
ack  in  1  receiver acknowledge of a complete frame
ld  out  1  high during LOAD (word captured)
rts  out  1  request-to-send, high in REQ
sdo  out  1  serial data out
clkout  out  1  serial bit clock
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse, frame acknowledged
err  out  1  one-cycle pulse, timeout abort

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high on rst.
- Reset: state=IDLE, shift register=0, counters=0; all outputs 0. rst wins over every other input. rst mid-frame aborts in one cycle with no done or err.
- Outputs are registered or decoded from state only, with no input-to-output combinational paths.
- IDLE: send=1 -> LOAD and din is captured. send is ignored in all other states.
- LOAD, 1 cycle: ld=1. Next state is REQ and the timeout counter clears.
- REQ: rts=1.
  - txe=1 -> SHIFT with bit counter=0 and phase=0.
  - Otherwise the counter increments. When it reaches TIMEOUT (TIMEOUT>0) -> ERR.
- SHIFT: each bit takes 2 cycles.
  - Phase 0: sdo = current bit, clkout=0.
  - Phase 1: sdo is held, clkout=1, and the register shifts after this phase.
  - Bit order follows MSB_FIRST.
  - After NBITS bits (NBITS=DATA_W, or DATA_W+1 with parity) -> WAIT_ACK. SHIFT lasts exactly 2*NBITS cycles.
  - txe is not re-checked during SHIFT.
- WAIT_ACK: sdo=0, clkout=0, the counter clears on entry.
  - ack=1 -> DONE.
  - Counter reaching TIMEOUT -> ERR.
  - ack asserted in any other state is ignored.
- DONE, 1 cycle: done=1 -> IDLE.
- ERR, 1 cycle: err=1 -> IDLE.
- Back-to-back frames: send held high in IDLE starts the next frame on the cycle after DONE or ERR returns to IDLE.
- Latency with txe and ack already high: send edge to done pulse = 1 (LOAD) + 1 (REQ) + 2*NBITS + 1 (WAIT_ACK) + 1 cycles.
- The bit counter is $clog2(NBITS+1) wide and the timeout counter is $clog2(TIMEOUT+1) wide (minimum 1). Neither wraps; both saturate at their terminal value.

Optional Feature:
STS_PARITY_EN:
- Defined: one even-parity bit (XOR of the captured word) is sent as the last bit after the data, with the same 2-cycle timing, so NBITS=DATA_W+1.
- Undefined: no parity logic and NBITS=DATA_W.

Test Plan:
- Basic frame (DATA_W=8, LSB first, no parity): send=1 with din=8'hA5, txe=1, ack=1 -> ld at cycle 1, rts at 2, sdo bits 1,0,1,0,0,1,0,1 with 8 clkout pulses over cycles 3..18, done pulse at cycle 20, busy low at 21.
- MSB_FIRST=1, din=8'h81, then 8'h01 -> sdo 1,0,0,0,0,0,0,1 for the first word and 0,0,0,0,0,0,0,1 for the second.
- REQ timeout: TIMEOUT=4, txe held 0 -> rts high for 4 cycles, then an err pulse, no clkout pulses, IDLE.
- ACK timeout and late ack: ack held 0 -> err after 16 cycles in WAIT_ACK. Repeat with ack raised on the 10th WAIT_ACK cycle -> done, no err.
- Reset mid-frame: assert rst after 3 clkout pulses -> next cycle all outputs 0, no done or err. A following send=1 with din=8'h3C transmits cleanly.
- STS_PARITY_EN defined: din=8'h07 -> 9 clkout pulses with last sdo=1. din=8'h03 -> last sdo=0.
